// File: rtl/gpio_int_dispatch.sv
// GPIO interrupt dispatcher: snapshots GPIO status, requests the lowest pending
// line from the core, waits for EOI and pulses the matching clear bit back.
module gpio_int_dispatch #(
    parameter int unsigned ACK_TIMEOUT = 256,
    parameter int unsigned HOLDOFF     = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             intr_i,
    input  logic [31:0]      gpio_int_status_i,
    output logic [31:0]      gpio_int_clr_o,
    output logic             irq_o,
    output logic [4:0]       irq_id_o,
    input  logic             irq_ack_i,
    input  logic             eoi_i,
    output logic             busy_o,
    output logic             timeout_o,
    input  logic             timeout_clr_i,
    output logic [CNT_W-1:0] irq_count_o
);

    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT);
    localparam int unsigned HO_W = $clog2(HOLDOFF + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SERVICE = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;
    localparam logic [2:0] S_HOLDOFF = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      snap_q, snap_d;
    logic [4:0]       id_q, id_d;
    logic             irq_q, irq_d;
    logic [31:0]      clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;

    logic             sel_found;
    logic [4:0]       sel_id;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!sel_found && snap_q[i]) begin
                sel_found = 1'b1;
                sel_id    = 5'(i);
            end
        end
    end

    // The clear pulse is loaded on entry to CLEAR so it coincides with that state.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        id_d      = id_q;
        irq_d     = irq_q;
        clr_d     = '0;
        timeout_d = timeout_q;
        count_d   = count_q;
        to_cnt_d  = to_cnt_q;
        ho_cnt_d  = ho_cnt_q;

        if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (intr_i && enable_i) begin
                    snap_d  = gpio_int_status_i;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (snap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    id_d     = sel_id;
                    irq_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    irq_d   = 1'b0;
                    state_d = S_SERVICE;
                end else if (to_cnt_q == TO_LAST) begin
                    irq_d     = 1'b0;
                    timeout_d = 1'b1;
                    clr_d     = 32'(1) << id_q;
                    state_d   = S_CLEAR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_SERVICE: begin
                if (eoi_i) begin
                    count_d = count_q + 1'b1;
                    clr_d   = 32'(1) << id_q;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ho_cnt_d = '0;
                state_d  = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (ho_cnt_q == HO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            id_q      <= '0;
            irq_q     <= 1'b0;
            clr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            to_cnt_q  <= '0;
            ho_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            id_q      <= id_d;
            irq_q     <= irq_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            to_cnt_q  <= to_cnt_d;
            ho_cnt_q  <= ho_cnt_d;
        end
    end

    assign gpio_int_clr_o = clr_q;
    assign irq_o          = irq_q;
    assign irq_id_o       = id_q;
    assign busy_o         = busy_q;
    assign timeout_o      = timeout_q;
    assign irq_count_o    = count_q;

endmodule

// File: tb/tb_gpio_int_dispatch.sv
// Self-checking bench for gpio_int_dispatch with a GPIO status emulator and a
// transaction-level scoreboard of expected IDs, clears, count and timeout flag.
module tb_gpio_int_dispatch;

    localparam int unsigned ACK_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        intr_drv = 1'b0;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;
    logic        to_clr = 1'b0;
    logic [31:0] gpio_raw = '0;
    logic [31:0] gpio_done = '0;
    logic [31:0] raw_seen = '0;
    logic [31:0] gpio_status;
    logic        intr;

    logic [31:0] clr_o;
    logic        irq;
    logic [4:0]  irq_id;
    logic        busy;
    logic        timeout;
    logic [15:0] count;

    int          checks = 0;
    int          errors = 0;
    int          m_count = 0;
    logic        m_timeout = 1'b0;
    int          exp_id = 0;
    logic [31:0] clr_exp[$];

    // GPIO block emulation: a bit drops once its clear pulse has been seen.
    assign gpio_status = gpio_raw & ~gpio_done;
    assign intr        = intr_drv | (|gpio_status);

    gpio_int_dispatch #(
        .ACK_TIMEOUT(ACK_TO),
        .HOLDOFF(2),
        .CNT_W(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .enable_i(enable),
        .intr_i(intr),
        .gpio_int_status_i(gpio_status),
        .gpio_int_clr_o(clr_o),
        .irq_o(irq),
        .irq_id_o(irq_id),
        .irq_ack_i(ack),
        .eoi_i(eoi),
        .busy_o(busy),
        .timeout_o(timeout),
        .timeout_clr_i(to_clr),
        .irq_count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        logic [31:0] iso;
        iso = v & (~v + 32'd1);
        return $clog2(iso);
    endfunction

    always @(negedge clk) begin
        if (gpio_raw != raw_seen) begin
            raw_seen  = gpio_raw;
            gpio_done = '0;
        end
        if (rst_n) begin
            if (irq) chk("irq_id", {27'd0, irq_id}, exp_id);
            if (clr_o != '0) begin
                if (clr_exp.size() == 0) chk("clr_unexpected", clr_o, 32'd0);
                else chk("clr_vec", clr_o, clr_exp.pop_front());
                chk("busy_on_clr", {31'd0, busy}, 32'd1);
                gpio_done = gpio_done | clr_o;
            end
            chk("count", {16'd0, count}, m_count);
            chk("timeout", {31'd0, timeout}, {31'd0, m_timeout});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input logic [31:0] v);
        gpio_raw = '0;
        cyc();
        gpio_raw = v;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq && n < 40) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, irq}, 32'd1);
    endtask

    task automatic model_dispatch();
        exp_id = lowest(gpio_status);
        clr_exp.push_back(32'd1 << exp_id);
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int ids[3] = '{0, 5, 31};

        enable = 1'b1;
        repeat (3) cyc();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_clr", clr_o, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single line with latency, pulse width and holdoff
        set_status(32'h0000_0010);
        cyc();
        chk("t1_lat_sel", {31'd0, irq}, 32'd0);
        cyc();
        chk("t1_lat_req", {31'd0, irq}, 32'd1);
        model_dispatch();
        chk("t1_id", {27'd0, irq_id}, 32'd4);
        repeat (3) cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t1_ack_drop", {31'd0, irq}, 32'd0);
        repeat (5) cyc();
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
        m_count++;
        chk("t1_clr", clr_o, 32'h0000_0010);
        cyc();
        chk("t1_clr_end", clr_o, 32'd0);
        wait_idle("t1_idle", n);
        chk("t1_holdoff", n, 32'd2);
        chk("t1_count", {16'd0, count}, 32'd1);

        // Priority across three passes
        set_status(32'h8000_0021);
        for (int k = 0; k < 3; k++) begin
            wait_irq("t2_irq");
            model_dispatch();
            chk("t2_id", {27'd0, irq_id}, ids[k]);
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            cyc();
            eoi = 1'b1;
            cyc();
            eoi = 1'b0;
            m_count++;
            wait_idle("t2_idle", n);
        end
        chk("t2_count", {16'd0, count}, 32'd4);
        chk("t2_all_clr", clr_exp.size(), 32'd0);

        // Acknowledge timeout
        set_status(32'h0000_0004);
        wait_irq("t3_irq");
        model_dispatch();
        n = 0;
        while (irq && n < 20) begin
            cyc();
            n++;
        end
        m_timeout = 1'b1;
        chk("t3_irq_width", n, ACK_TO);
        chk("t3_clr", clr_o, 32'h0000_0004);
        chk("t3_flag", {31'd0, timeout}, 32'd1);
        wait_idle("t3_idle", n);
        chk("t3_count", {16'd0, count}, 32'd4);
        to_clr = 1'b1;
        cyc();
        to_clr = 1'b0;
        m_timeout = 1'b0;
        chk("t3_flag_clr", {31'd0, timeout}, 32'd0);

        // Ack on the final REQ cycle wins over timeout
        set_status(32'h0000_0040);
        wait_irq("t4_irq");
        model_dispatch();
        repeat (ACK_TO - 1) cyc();
        chk("t4_still_req", {31'd0, irq}, 32'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t4_irq_drop", {31'd0, irq}, 32'd0);
        chk("t4_no_timeout", {31'd0, timeout}, 32'd0);
        repeat (2) cyc();
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
        m_count++;
        chk("t4_clr", clr_o, 32'h0000_0040);
        wait_idle("t4_idle", n);
        chk("t4_count", {16'd0, count}, 32'd5);

        // Timeout set and clear in the same cycle: set wins
        set_status(32'h0000_0100);
        wait_irq("t5_irq");
        model_dispatch();
        repeat (ACK_TO - 1) cyc();
        to_clr = 1'b1;
        cyc();
        to_clr = 1'b0;
        m_timeout = 1'b1;
        chk("t5_set_wins", {31'd0, timeout}, 32'd1);
        wait_idle("t5_idle", n);

        // Spurious interrupt with empty status
        intr_drv = 1'b1;
        cyc();
        intr_drv = 1'b0;
        chk("t6_select_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("t6_back_idle", {31'd0, busy}, 32'd0);
        repeat (3) cyc();
        chk("t6_no_irq", {31'd0, irq}, 32'd0);

        // Enable gating, then enable dropped during SERVICE
        enable = 1'b0;
        set_status(32'h0000_0002);
        repeat (5) cyc();
        chk("t7_gated_busy", {31'd0, busy}, 32'd0);
        chk("t7_gated_irq", {31'd0, irq}, 32'd0);
        enable = 1'b1;
        wait_irq("t7_irq");
        model_dispatch();
        chk("t7_id", {27'd0, irq_id}, 32'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        enable = 1'b0;
        cyc();
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
        m_count++;
        chk("t7_clr", clr_o, 32'h0000_0002);
        wait_idle("t7_idle", n);
        enable = 1'b1;

        // Asynchronous reset in SERVICE, then fresh dispatch
        set_status(32'h0000_0008);
        wait_irq("t8_irq");
        model_dispatch();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        m_count = 0;
        m_timeout = 1'b0;
        clr_exp.delete();
        #1;
        chk("t8_rst_irq", {31'd0, irq}, 32'd0);
        chk("t8_rst_clr", clr_o, 32'd0);
        chk("t8_rst_busy", {31'd0, busy}, 32'd0);
        chk("t8_rst_timeout", {31'd0, timeout}, 32'd0);
        chk("t8_rst_count", {16'd0, count}, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        wait_irq("t8_irq2");
        model_dispatch();
        chk("t8_id", {27'd0, irq_id}, 32'd3);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
        m_count++;
        chk("t8_clr", clr_o, 32'h0000_0008);
        wait_idle("t8_idle", n);
        chk("t8_count", {16'd0, count}, 32'd1);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
